// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit seven-segment driver: prescaled digit scan, double-buffered
// display data, per-digit blanking, decimal points and leading-zero suppression.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic                          lzs,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(CLK_DIV);

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
  // Inactive pin levels; XOR with these turns active-high intent into pin polarity.
  localparam logic [6:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]      presc_r;
  logic [IDX_W-1:0]      idx_r;
  logic [3:0]            shadow_dig_r [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp_r;
  logic [NUM_DIGITS-1:0] shadow_blank_r;

  logic                  tick_s;
  logic                  zero_run_s;
  logic [NUM_DIGITS-1:0] lead_zero_s;
  logic                  suppress_s;
  logic [3:0]            cur_nib_s;
  logic [6:0]            seg_on_s;
  logic                  dp_on_s;
  logic [NUM_DIGITS-1:0] an_on_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      4'hF:    s = 7'b1110001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick_s = (presc_r == PRE_LAST);

  // Prescaler and scan index; the index moves on when the prescaler wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PRE_W{1'b0}};
      idx_r   <= IDX_ZERO;
    end else if (tick_s) begin
      presc_r <= {PRE_W{1'b0}};
      idx_r   <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_W'(1);
    end else begin
      presc_r <= presc_r + PRE_W'(1);
      idx_r   <= idx_r;
    end
  end

  // Shadow registers: the scan only ever reads these, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_dig_r[i] <= 4'h0;
      end
      shadow_dp_r    <= {NUM_DIGITS{1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b1}};
    end else if (load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_dig_r[i] <= digits[4*i +: 4];
      end
      shadow_dp_r    <= dp_in;
      shadow_blank_r <= blank_in;
    end else begin
      shadow_dp_r    <= shadow_dp_r;
      shadow_blank_r <= shadow_blank_r;
    end
  end

  // lead_zero_s[i]: digit i and every digit above it are zero.
  always_comb begin
    zero_run_s  = 1'b1;
    lead_zero_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s     = zero_run_s && (shadow_dig_r[i] == 4'h0);
      lead_zero_s[i] = zero_run_s;
    end
  end

  // Active-high pin intent for the currently scanned digit.
  always_comb begin
    cur_nib_s  = shadow_dig_r[idx_r];
    suppress_s = lzs && (idx_r != IDX_ZERO) && lead_zero_s[idx_r];
    seg_on_s   = 7'h00;
    dp_on_s    = 1'b0;
    an_on_s    = {NUM_DIGITS{1'b0}};
    if (shadow_blank_r[idx_r]) begin
      an_on_s  = {NUM_DIGITS{1'b0}};
    end else begin
      an_on_s[idx_r] = 1'b1;
      dp_on_s        = shadow_dp_r[idx_r];
      if (suppress_s) begin
        seg_on_s = 7'h00;
      end else begin
        seg_on_s = hex_to_seg(cur_nib_s);
      end
    end
  end

  // Output register: an and seg switch together on one edge, so no ghosting.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      digit_idx <= IDX_ZERO;
    end else begin
      seg       <= seg_on_s ^ SEG_OFF;
      dp        <= dp_on_s ^ DP_OFF;
      an        <= an_on_s ^ AN_OFF;
      digit_idx <= idx_r;
    end
  end

endmodule
